// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Boot sequencer for the Hack instruction ROM. A START pulse holds the CPU in
//   reset and arms a frame parser on the UART RX byte stream:
//     SYNC_BYTE, LEN_HI, LEN_LO, N x {hi, lo}, CSUM
//   Each word is written to the ROM write port one cycle after its low byte.
//   The CPU is released only when the 8-bit wrapping checksum over the length
//   and data bytes matches.
// Ports
//   CLK_100MHz, RESET          clock, async active-high reset
//   START                      1-cycle pulse, begin/restart a load
//   RX_DATA, RX_VALID          received byte + strobe
//   WR_EN, WR_ADDR, WR_DATA    ROM write port (registered)
//   CPU_HOLD                   ORed into CPU reset at top level
//   BUSY                       parser active (not IDLE/DONE/ERROR)
//   LOAD_OK, LOAD_ERR          sticky result of the last load
module uart_boot_loader #(
  parameter int          ADDR_W         = 15,
  parameter int          TIMEOUT_CYCLES = 10_000_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic              CLK_100MHz,
  input  logic              RESET,
  input  logic              START,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [15:0]       WR_DATA,
  output logic              CPU_HOLD,
  output logic              BUSY,
  output logic              LOAD_OK,
  output logic              LOAD_ERR
);

  localparam int          TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  // ROM capacity in words; a length above this can never fit.
  localparam logic [31:0] CAP  = 32'd1 << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  // One bit wider than the address so index+1 can equal a full-ROM length.
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     idx_next;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          hi_q, hi_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                hold_q, hold_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic                timed;
  logic [15:0]         n_len;

  assign idx_next = idx_q + 1'b1;
  assign n_len    = {len_q[15:8], RX_DATA};
  assign timed    = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                    (state_q == S_CSUM);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    hi_d      = hi_q;
    timer_d   = timer_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    ok_d      = ok_q;
    err_d     = err_q;

    // START has priority over everything, including a byte in the same cycle.
    if (START) begin
      state_d = S_SYNC;
      hold_d  = 1'b1;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      idx_d   = '0;
      csum_d  = '0;
      timer_d = '0;
    end else if (state_q == S_SYNC) begin
      if (RX_VALID && RX_DATA == SYNC_BYTE) state_d = S_LEN_HI;
    end else if (timed) begin
      if (RX_VALID) begin
        timer_d = '0;
        if (state_q != S_CSUM) csum_d = csum_q + RX_DATA;
        case (state_q)
          S_LEN_HI: begin
            len_d[15:8] = RX_DATA;
            state_d     = S_LEN_LO;
          end
          S_LEN_LO: begin
            len_d = n_len;
            if (32'(n_len) > CAP) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end else if (n_len == 16'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            hi_d    = RX_DATA;
            state_d = S_DATA_LO;
          end
          S_DATA_LO: begin
            // Registered write lands on the cycle after the low byte.
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q[ADDR_W-1:0];
            wr_data_d = {hi_q, RX_DATA};
            idx_d     = idx_next;
            state_d   = (32'(idx_next) == 32'(len_q)) ? S_CSUM : S_DATA_HI;
          end
          S_CSUM: begin
            if (RX_DATA == csum_q) begin
              state_d = S_DONE;
              hold_d  = 1'b0;
              ok_d    = 1'b1;
            end else begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (timer_q == TMAX) begin
        // CPU_HOLD is left asserted so a partial image never runs.
        state_d = S_ERROR;
        err_d   = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      hi_q      <= '0;
      timer_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      hi_q      <= hi_d;
      timer_q   <= timer_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign WR_EN    = wr_en_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;
  assign CPU_HOLD = hold_q;
  assign LOAD_OK  = ok_q;
  assign LOAD_ERR = err_q;
  assign BUSY     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  localparam int ADDR_W = 15;
  localparam int TMO    = 100;
  localparam int GAP    = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              cpu_hold, busy, load_ok, load_err;

  uart_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
    .CLK_100MHz(clk), .RESET(rst), .START(start), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .CPU_HOLD(cpu_hold),
    .BUSY(busy), .LOAD_OK(load_ok), .LOAD_ERR(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  // Status request: {LOAD_OK, LOAD_ERR, CPU_HOLD, BUSY}, plus a write-queue drain check.
  typedef struct {
    string      name;
    logic [3:0] st;
  } st_t;

  wr_t wr_q[$];
  st_t st_q[$];
  int  checks = 0;
  int  errors = 0;

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    if (wr_en) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%h, expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          errors++;
          $display("FAIL write: got (%0h,%h), expected (%0h,%h)", wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
    if (st_q.size() != 0) begin
      st_t s;
      s = st_q.pop_front();
      checks++;
      if ({load_ok, load_err, cpu_hold, busy} !== s.st) begin
        errors++;
        $display("FAIL %s: got ok/err/hold/busy=%b, expected %b", s.name,
                 {load_ok, load_err, cpu_hold, busy}, s.st);
      end
      checks++;
      if (wr_q.size() != 0) begin
        errors++;
        $display("FAIL %s_drain: got %0d pending writes, expected 0", s.name, wr_q.size());
        wr_q.delete();
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic exp_st(input string name, input logic [3:0] st);
    st_t s;
    s.name = name;
    s.st   = st;
    st_q.push_back(s);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_st("reset_held", 4'b0000);
    rst = 1'b0;
    @(negedge clk);

    // 1: idle after reset, stray sync byte ignored
    exp_st("reset_state", 4'b0000);
    send_byte(8'hA5);
    exp_st("stray_idle_byte", 4'b0000);

    // 2: two-word frame, good checksum
    pulse_start();
    exp_st("busy_after_start", 4'b0011);
    exp_wr(0, 16'h1234);
    exp_wr(1, 16'hABCD);
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0});
    exp_st("good_frame", 4'b1000);

    // 3: same frame, bad checksum
    pulse_start();
    exp_wr(0, 16'h1234);
    exp_wr(1, 16'hABCD);
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1});
    exp_st("bad_csum", 4'b0110);

    // 4: junk before sync, zero-length frame
    pulse_start();
    send_bytes('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00});
    exp_st("zero_len", 4'b1000);

    // 5: length exceeds ROM capacity
    pulse_start();
    send_bytes('{8'hA5, 8'h80, 8'h01});
    exp_st("len_too_big", 4'b0110);

    // 6: inter-byte timeout (100 cycles after last byte)
    pulse_start();
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'h12});
    repeat (75) @(negedge clk);
    exp_st("before_timeout", 4'b0011);
    repeat (25) @(negedge clk);
    exp_st("after_timeout", 4'b0110);

    // START mid-frame restarts at SYNC, then a full frame passes
    pulse_start();
    send_bytes('{8'hA5, 8'h00, 8'h01});
    pulse_start();
    exp_st("restart_mid_frame", 4'b0011);
    exp_wr(0, 16'h1234);
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h47});
    exp_st("after_restart", 4'b1000);

    // START and RX_VALID together: the sync byte must be dropped
    @(negedge clk);
    start = 1'b1; rx_data = 8'hA5; rx_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    repeat (GAP) @(negedge clk);
    exp_wr(0, 16'h5678);
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'h56, 8'h78, 8'hCF});
    exp_st("start_beats_rx", 4'b1000);

    // RESET mid-load returns to idle with the CPU released
    pulse_start();
    send_bytes('{8'hA5, 8'h00, 8'h01});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_bytes('{8'h12, 8'h34});
    exp_st("reset_mid_load", 4'b0000);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
